tinyalu_scheduler: RTL

//  Shares one tinyalu (A/B/op/start -> done/result) between NUM_REQ requesters.
//  - Round-robin arbitration; one operation in flight at a time.
//  - Holds start high until done, then returns the result tagged with the requester id.
//  - Completes NOP locally and rejects illegal opcodes without touching the ALU.

---
 rtl/tinyalu_scheduler_pkg.sv | 26 ++
 rtl/tinyalu_scheduler_if.sv | 36 +++
 rtl/tinyalu_scheduler_rr_arbiter.sv | 30 +++
 rtl/tinyalu_scheduler.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/tinyalu_scheduler_pkg.sv
// Shared types and helpers for the tinyalu scheduler: opcode and FSM state enums.
package tinyalu_pkg;

  typedef enum logic [2:0] {
    NOP = 3'b000,
    ADD = 3'b001,
    AND = 3'b010,
    XOR = 3'b011,
    MUL = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } sched_state_e;

  function automatic logic is_alu_op(input logic [2:0] op);
    return (op >= 3'b001) && (op <= 3'b100);
  endfunction

  function automatic logic is_illegal_op(input logic [2:0] op);
    return op >= 3'b101;
  endfunction

endpackage

// File: rtl/tinyalu_scheduler_if.sv
// Requester, response and tinyalu-side signals of the scheduler, bundled with views for both ends.
interface tinyalu_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*8-1:0] req_A;
  logic [NUM_REQ*8-1:0] req_B;
  logic [NUM_REQ*3-1:0] req_op;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [15:0]          rsp_result;
  logic                 rsp_err;
  logic [7:0]           alu_A;
  logic [7:0]           alu_B;
  logic [2:0]           alu_op;
  logic                 alu_start;
  logic                 alu_done;
  logic [15:0]          alu_result;

  // Scheduler view
  modport slave (
    input  req_valid, req_A, req_B, req_op, rsp_ready, alu_done, alu_result,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err,
           alu_A, alu_B, alu_op, alu_start
  );

  // Environment view: requesters, response sink and the tinyalu itself
  modport master (
    output req_valid, req_A, req_B, req_op, rsp_ready, alu_done, alu_result,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err,
           alu_A, alu_B, alu_op, alu_start
  );
endinterface

// File: rtl/tinyalu_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after last_grant, wrapping modulo N.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int c;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(last_grant) + k) % N;
      if (!any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/tinyalu_scheduler.sv
// Round-robin scheduler sharing one tinyalu among NUM_REQ requesters.
// Optional BUSY watchdog enabled by defining ALU_SCHED_TIMEOUT_EN.
module tinyalu_scheduler
  import tinyalu_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic           clk,
  input logic           reset,
  tinyalu_scheduler_if.slave bus
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_param
    $error("tinyalu_scheduler: NUM_REQ must be 2..4 and TIMEOUT_CYCLES 1..255");
  end

  sched_state_e        state, state_n;
  logic [ID_W-1:0]     last_grant;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     gidx;
  logic                gany;
  int                  gsel;
  logic [7:0]          sel_A, sel_B;
  logic [2:0]          sel_op;
  logic [NUM_REQ-1:0]  req_ready;
  logic                alu_start;
  logic [7:0]          alu_A, alu_B;
  logic [2:0]          alu_op;
  logic [ID_W-1:0]     rsp_id;
  logic [15:0]         rsp_result;
  logic                rsp_err;
  logic                timeout_hit;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(ID_W)) u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .idx        (gidx),
    .any        (gany)
  );

  assign gsel   = int'(gidx);
  assign sel_A  = bus.req_A[gsel*8 +: 8];
  assign sel_B  = bus.req_B[gsel*8 +: 8];
  assign sel_op = bus.req_op[gsel*3 +: 3];

`ifdef ALU_SCHED_TIMEOUT_EN
  logic [7:0] wdog;
  assign timeout_hit = (wdog == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (gany) begin
          req_ready = grant;
          state_n   = is_alu_op(sel_op) ? BUSY : RESP;
        end
      end
      BUSY: begin
        if (bus.alu_done || timeout_hit) state_n = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      alu_start  <= 1'b0;
      alu_A      <= '0;
      alu_B      <= '0;
      alu_op     <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
`ifdef ALU_SCHED_TIMEOUT_EN
      wdog       <= '0;
`endif
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (gany) begin
            alu_A      <= sel_A;
            alu_B      <= sel_B;
            alu_op     <= sel_op;
            rsp_id     <= gidx;
            rsp_result <= '0;
            rsp_err    <= is_illegal_op(sel_op);
            alu_start  <= is_alu_op(sel_op);
`ifdef ALU_SCHED_TIMEOUT_EN
            wdog       <= '0;
`endif
          end
        end
        BUSY: begin
          // alu_result is only trusted on the alu_done cycle
          if (bus.alu_done) begin
            rsp_result <= bus.alu_result;
            rsp_err    <= 1'b0;
            alu_start  <= 1'b0;
          end else if (timeout_hit) begin
            rsp_result <= '0;
            rsp_err    <= 1'b1;
            alu_start  <= 1'b0;
          end
`ifdef ALU_SCHED_TIMEOUT_EN
          else begin
            wdog <= wdog + 8'd1;
          end
`endif
        end
        RESP: begin
          if (bus.rsp_ready) last_grant <= rsp_id;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = rsp_id;
  assign bus.rsp_result = rsp_result;
  assign bus.rsp_err    = rsp_err;
  assign bus.alu_A      = alu_A;
  assign bus.alu_B      = alu_B;
  assign bus.alu_op     = alu_op;
  assign bus.alu_start  = alu_start;

endmodule
